// File: rtl/mvm3_stream_host_if.sv
// Streaming link between mvm3_stream_host (master) and the mvm3 multiplier (slave).
// Carries the 8-bit input word channel and the 16-bit result channel with its overflow flag.
interface mvm3_stream_host_if;
    logic signed [7:0]  m_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic               s_overflow;

    modport master (
        output m_data, m_valid, s_ready,
        input  m_ready, s_data, s_valid, s_overflow
    );

    modport slave (
        input  m_data, m_valid, s_ready,
        output m_ready, s_data, s_valid, s_overflow
    );
endinterface

// File: rtl/mvm3_stream_host.sv
// Host-side job buffer for mvm3: streams a loaded A/B/X job into the multiplier and
// captures its results and overflow flags for host readback.
module mvm3_stream_host #(
    parameter int unsigned NROWS_A     = 3,
    parameter int unsigned NCOLS_A     = 3,
    parameter int unsigned NROWS_B     = 3,
    parameter int unsigned NCOLS_B     = 3,
    parameter int unsigned NUM_RESULTS = 3,
    localparam int unsigned IN_WORDS   = NROWS_A * NCOLS_A + 2 * NROWS_B * NCOLS_B,
    localparam int unsigned IW         = $clog2(IN_WORDS),
    localparam int unsigned RW         = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1,
    localparam int unsigned CW         = $clog2(NUM_RESULTS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                host_wr_en,
    input  logic [IW-1:0]       host_addr,
    input  logic signed [7:0]   host_wr_data,
    input  logic [RW-1:0]       host_rd_addr,
    output logic signed [15:0]  host_rd_data,
    output logic                host_rd_ovf,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       ovf_count,
    mvm3_stream_host_if.master  bus
);

    localparam logic [IW-1:0] LastWord = IW'(IN_WORDS - 1);
    localparam logic [CW-1:0] ResFull  = CW'(NUM_RESULTS);
    localparam logic [CW-1:0] LastRes  = CW'(NUM_RESULTS - 1);

    typedef enum logic [2:0] {StIdle, StPrefetch, StSend, StCollect, StDone} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         send_idx_q, send_idx_d;
    logic signed [7:0]     m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic [CW-1:0]         res_idx_q, res_idx_d;
    logic [CW-1:0]         ovf_count_q, ovf_count_d;
    logic signed [15:0]    host_rd_data_q;
    logic                  host_rd_ovf_q;

    logic signed [7:0]     in_mem [IN_WORDS];
    logic [16:0]           res_mem [NUM_RESULTS];

    logic s_ready_c, m_xfer, s_acc, last_res_acc, res_full_next, wr_ok;

    // Result side only listens while a job is streaming and the result buffer has room.
    assign s_ready_c     = ((state_q == StSend) || (state_q == StCollect)) &&
                           (res_idx_q != ResFull);
    assign m_xfer        = m_valid_q && bus.m_ready;
    assign s_acc         = bus.s_valid && s_ready_c;
    assign last_res_acc  = s_acc && (res_idx_q == LastRes);
    assign res_full_next = (res_idx_q == ResFull) || last_res_acc;
    assign wr_ok         = (state_q == StIdle) && host_wr_en && (32'(host_addr) < IN_WORDS);

    always_comb begin
        state_d     = state_q;
        send_idx_d  = send_idx_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        res_idx_d   = res_idx_q;
        ovf_count_d = ovf_count_q;

        if (s_acc) begin
            res_idx_d = res_idx_q + CW'(1);
            if (bus.s_overflow && (ovf_count_q != ResFull)) begin
                ovf_count_d = ovf_count_q + CW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StPrefetch;
                    send_idx_d  = '0;
                    res_idx_d   = '0;
                    ovf_count_d = '0;
                end
            end
            StPrefetch: begin
                m_data_d   = in_mem[0];
                m_valid_d  = 1'b1;
                send_idx_d = '0;
                state_d    = StSend;
            end
            StSend: begin
                if (m_xfer) begin
                    if (send_idx_q == LastWord) begin
                        m_valid_d = 1'b0;
                        state_d   = res_full_next ? StDone : StCollect;
                    end else begin
                        // Next word is fetched on the transfer edge to keep one word per cycle.
                        send_idx_d = send_idx_q + IW'(1);
                        m_data_d   = in_mem[send_idx_q + IW'(1)];
                    end
                end
            end
            StCollect: begin
                if (last_res_acc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            send_idx_q     <= '0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            res_idx_q      <= '0;
            ovf_count_q    <= '0;
            host_rd_data_q <= '0;
            host_rd_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            send_idx_q  <= send_idx_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            res_idx_q   <= res_idx_d;
            ovf_count_q <= ovf_count_d;
            if (32'(host_rd_addr) < NUM_RESULTS) begin
                {host_rd_ovf_q, host_rd_data_q} <= res_mem[host_rd_addr];
            end else begin
                host_rd_ovf_q  <= 1'b0;
                host_rd_data_q <= '0;
            end
        end
    end

    // Buffers carry no reset so a reset mid-job keeps the loaded input job.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            in_mem[host_addr] <= host_wr_data;
        end
        if (!reset && s_acc) begin
            res_mem[res_idx_q[RW-1:0]] <= {bus.s_overflow, bus.s_data};
        end
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.s_ready = s_ready_c;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign ovf_count   = ovf_count_q;
    assign host_rd_data = host_rd_data_q;
    assign host_rd_ovf  = host_rd_ovf_q;

endmodule

// File: doc/mvm3_stream_host.md
Name: mvm3_stream_host

Overview:
Bus-side partner of the mvm3 matrix-vector multiplier. It holds one input job (matrix A, then B, then X, as signed 8-bit words) in a host-loaded buffer and streams it into the multiplier's slave port. It then collects the multiplier's 16-bit results and overflow flags into a result buffer that the host can read back. It is the master on the multiplier's input interface and the slave on its output interface.

Parameters:
NROWS_A, 3, rows of A
NCOLS_A, 3, cols of A
NROWS_B, 3, rows of B (and X)
NCOLS_B, 3, cols of B (and X)
NUM_RESULTS, 3, results expected per job
Derived: IN_WORDS = NROWS_A*NCOLS_A + 2*NROWS_B*NCOLS_B (27); IW = $clog2(IN_WORDS); RW = max(1,$clog2(NUM_RESULTS)); CW = $clog2(NUM_RESULTS+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
host_wr_en  in  1  write input buffer (honoured in IDLE only)
host_addr  in  IW  input buffer write address
host_wr_data  in  8  signed input word
host_rd_addr  in  RW  result buffer read address
host_rd_data  out  16  signed result, registered, 1-cycle read latency
host_rd_ovf  out  1  overflow flag of that result, same timing
start  in  1  begin job (honoured in IDLE only)
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse when the last result is stored
ovf_count  out  CW  number of results in the current/last job with overflow set
m_data  out  8  signed word to the multiplier's data_in
m_valid  out  1  word valid
m_ready  in  1  multiplier's s_ready
s_data  in  16  multiplier's data_out
s_valid  in  1  multiplier's m_valid
s_ready  out  1  multiplier's m_ready
s_overflow  in  1  multiplier's overflow

Behaviour:
- Reset values: state=IDLE, m_valid=0, s_ready=0, busy=0, done=0, ovf_count=0, host_rd_data=0, host_rd_ovf=0, send/result indices=0. Buffer contents are not reset.
- Transfer rules: a word transfers when m_valid&&m_ready; a result is accepted when s_valid&&s_ready.
- Once m_valid rises, it stays high and m_data stays stable until the transfer completes. m_valid never depends combinationally on m_ready.
- State IDLE:
  - host_wr_en writes host_wr_data to host_addr.
  - start -> PREFETCH; this also clears ovf_count and the result index.
  - If host_wr_en and start are in the same cycle, the write lands before the read, so word 0 reflects the write.
- State PREFETCH (1 cycle): synchronous read of word 0 -> SEND. m_valid rises in the cycle after PREFETCH, i.e. 2 cycles after start is sampled.
- State SEND:
  - Words go out in order 0..IN_WORDS-1, one per cycle while m_ready=1 (full throughput, no bubbles).
  - When word IN_WORDS-1 transfers: m_valid=0 next cycle; next state is COLLECT, or DONE if all results are already stored.
- State COLLECT: wait for the remaining results.
- s_ready=1 in SEND and COLLECT, 0 otherwise. Results arriving in IDLE/PREFETCH/DONE are stalled, not dropped.
- On each result accept:
  - store {s_overflow, s_data} at the result index, then increment the index;
  - if s_overflow=1, increment ovf_count (saturating at NUM_RESULTS).
- Accepting result NUM_RESULTS-1 -> DONE, provided all words have been sent. If words remain, the index is held and the FSM goes to DONE after the last word transfers. Results beyond NUM_RESULTS are never accepted (s_ready=0 once the index is full).
- State DONE: done=1 for exactly one cycle -> IDLE. ovf_count and the result buffer hold until the next start.
- start or host_wr_en while busy=1: ignored, with no side effects.
- host_rd_addr is honoured in any state; a read of an index written in the same cycle returns the old value.
- reset mid-job: next cycle state=IDLE, m_valid=0, s_ready=0, busy=0. The input buffer is retained, so a new start resends from word 0.
- Width rules:
  - indices wrap nowhere (terminal compare at IN_WORDS-1 / NUM_RESULTS-1);
  - host_addr >= IN_WORDS writes are dropped;
  - host_rd_addr >= NUM_RESULTS returns 0.

Test Plan:
- Load words 1..27, start, m_ready=1 held -> m_data 1..27 on 27 consecutive cycles, first m_valid exactly 2 cycles after start, m_valid=0 after word 27, busy=1.
- Same load, m_ready pattern 1,0,0,1 repeating -> exactly 27 transfers, values 1..27 in order, m_data unchanged on every stalled cycle.
- After send, drive results 0x0010, 0xFFF0, 0x7FFF with s_valid gaps of 0/2/1 cycles, s_overflow=1 on the third -> done pulses once (cycle after third accept), ovf_count=1, host_rd_addr 0/1/2 return 16, -16, 32767 with ovf 0/0/1.
- While busy, pulse start and host_wr_en (addr 0, data 0x55) -> no restart; the next job's first m_data is still 1.
- Assert reset after 10 words sent -> m_valid=0, busy=0 next cycle; new start resends from word 1 (buffer intact).
- s_valid=1 while IDLE -> s_ready=0, result not stored, ovf_count unchanged; it is accepted once the next job enters SEND.
